// File: rtl/dst_axis_framer_pkg.sv
// Shared definitions for the result-stream framer: FSM state encoding and default widths.
package dst_axis_framer_pkg;

  localparam int unsigned DW_DEF   = 64;
  localparam int unsigned LENW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/axis_buf2.sv
// Two-entry register FIFO used as a skid buffer; head entry drives the pop side directly.
module axis_buf2 #(
  parameter int unsigned W = 65
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push_valid,
  input  logic [W-1:0] i_push_data,
  output logic         o_push_ready,
  output logic         o_pop_valid,
  output logic [W-1:0] o_pop_data,
  input  logic         i_pop_ready,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  assign o_full       = (r_cnt == 2'd2);
  assign o_empty      = (r_cnt == 2'd0);
  assign o_push_ready = !o_full;
  assign o_pop_valid  = !o_empty;
  assign o_pop_data   = r_head;
  assign w_push       = i_push_valid && o_push_ready;
  assign w_pop        = o_pop_valid && i_pop_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (o_empty) r_head <= i_push_data;
          else         r_tail <= i_push_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_cnt  <= r_cnt - 2'd1;
        end
        // push and pop together is only possible with exactly one entry held
        2'b11:   r_head <= i_push_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dst_axis_framer.sv
// Frames the accelerator result stream for the S2MM DMA: counts beats, tags TLAST,
// buffers through a 2-entry skid buffer with a registered TREADY, and pulses done.
module dst_axis_framer
  import dst_axis_framer_pkg::*;
#(
  parameter int unsigned DW   = DW_DEF,
  parameter int unsigned LENW = LENW_DEF
) (
  input  logic            AXIS_ACLK,
  input  logic            AXIS_ARESETN,
  input  logic            start,
  input  logic [LENW-1:0] len,
  output logic            busy,
  output logic            done,
  input  logic            S_AXIS_TVALID,
  input  logic [DW-1:0]   S_AXIS_TDATA,
  output logic            S_AXIS_TREADY,
  output logic            M_AXIS_TVALID,
  output logic [DW-1:0]   M_AXIS_TDATA,
  output logic [DW/8-1:0] M_AXIS_TSTRB,
  output logic            M_AXIS_TLAST,
  input  logic            M_AXIS_TREADY
);

  state_t          r_state;
  logic [LENW-1:0] r_len;
  logic [LENW-1:0] r_rcv_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_s_tready;

  logic            w_push_valid;
  logic            w_push_ready;
  logic            w_m_valid;
  logic [DW:0]     w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_s_hs;
  logic            w_m_hs;
  logic            w_s_last;
  logic            w_last_pop;
  logic [LENW-1:0] w_len_m1;
  logic [1:0]      w_occ;
  logic [1:0]      w_occ_nxt;

  assign w_push_valid = S_AXIS_TVALID && r_s_tready;
  assign w_s_hs       = w_push_valid && w_push_ready;
  assign w_m_hs       = w_m_valid && M_AXIS_TREADY;
  assign w_len_m1     = r_len - LENW'(1);
  assign w_s_last     = (r_rcv_cnt == w_len_m1);
  assign w_last_pop   = w_m_hs && w_head[DW];

  // Occupancy after this edge; lets TREADY be registered yet never overfill the buffer
  assign w_occ     = {w_full, !w_full && !w_empty};
  assign w_occ_nxt = w_occ + {1'b0, w_s_hs} - {1'b0, w_m_hs};

  axis_buf2 #(
    .W (DW + 1)
  ) u_buf (
    .i_clk        (AXIS_ACLK),
    .i_rst_n      (AXIS_ARESETN),
    .i_push_valid (w_push_valid),
    .i_push_data  ({w_s_last, S_AXIS_TDATA}),
    .o_push_ready (w_push_ready),
    .o_pop_valid  (w_m_valid),
    .o_pop_data   (w_head),
    .i_pop_ready  (M_AXIS_TREADY),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_rcv_cnt  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_s_tready <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_rcv_cnt <= '0;
            if (len != '0) begin
              r_len      <= len;
              r_state    <= ST_RUN;
              r_busy     <= 1'b1;
              r_s_tready <= 1'b1;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          r_s_tready <= (w_occ_nxt != 2'd2);
          if (w_s_hs) begin
            r_rcv_cnt <= r_rcv_cnt + LENW'(1);
            if (w_s_last) begin
              r_state    <= ST_DRAIN;
              r_s_tready <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (w_last_pop) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_s_tready <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign S_AXIS_TREADY = r_s_tready;
  assign M_AXIS_TVALID = w_m_valid;
  assign M_AXIS_TDATA  = w_head[DW-1:0];
  assign M_AXIS_TLAST  = w_m_valid && w_head[DW];
  assign M_AXIS_TSTRB  = {(DW/8){w_m_valid}};

endmodule

// File: tb/tb_dst_axis_framer.sv
// Scoreboard bench for dst_axis_framer: accepted beats are queued with their expected TLAST
// and compared in order against M_AXIS handshakes; done is predicted every cycle.
module tb_dst_axis_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic        busy;
  logic        done;
  logic        S_TVALID = 1'b0;
  logic [63:0] S_TDATA = '0;
  logic        S_TREADY;
  logic        M_TVALID;
  logic [63:0] M_TDATA;
  logic [7:0]  M_TSTRB;
  logic        M_TLAST;
  logic        M_TREADY = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_beats  = 0;
  int n_lasts  = 0;
  int unsigned cyc = 0;
  bit mon_en = 1'b0;
  bit rnd_m  = 1'b0;

  logic [64:0] exp_q[$];
  int unsigned s_hs_cyc[$];
  int unsigned m_hs_cyc[$];

  dst_axis_framer #(
    .DW   (64),
    .LENW (16)
  ) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESETN  (rst_n),
    .start         (start),
    .len           (len),
    .busy          (busy),
    .done          (done),
    .S_AXIS_TVALID (S_TVALID),
    .S_AXIS_TDATA  (S_TDATA),
    .S_AXIS_TREADY (S_TREADY),
    .M_AXIS_TVALID (M_TVALID),
    .M_AXIS_TDATA  (M_TDATA),
    .M_AXIS_TSTRB  (M_TSTRB),
    .M_AXIS_TLAST  (M_TLAST),
    .M_AXIS_TREADY (M_TREADY)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // previous-negedge snapshot used to predict done and check M-side hold
  logic        p_rstn = 1'b0, p_mvalid = 1'b0, p_mready = 1'b0, p_mlast = 1'b0;
  logic        p_start = 1'b0, p_busy = 1'b0;
  logic [15:0] p_len = '0;
  logic [63:0] p_mdata = '0;

  always @(negedge clk) begin
    logic        exp_done;
    logic [64:0] e;
    exp_done = p_rstn && ((p_mvalid && p_mready && p_mlast) ||
                          (p_start && !p_busy && p_len == 16'd0));
    if (mon_en) begin
      check_val("done", 72'(done), 72'(exp_done));
      if (p_rstn && p_mvalid && !p_mready) begin
        check_val("m_hold_valid", 72'(M_TVALID), 72'(1));
        check_val("m_hold_data", 72'({M_TLAST, M_TDATA}), 72'({p_mlast, p_mdata}));
      end
      if (rst_n && M_TVALID && M_TREADY) begin
        m_hs_cyc.push_back(cyc);
        n_beats++;
        if (M_TLAST) n_lasts++;
        check_val("m_strb", 72'(M_TSTRB), 72'(8'hFF));
        if (exp_q.size() == 0) begin
          check_val("m_extra_beat", 72'({M_TLAST, M_TDATA}), 72'(0));
        end else begin
          e = exp_q.pop_front();
          check_val("m_beat", 72'({M_TLAST, M_TDATA}), 72'(e));
        end
      end
    end
    p_rstn   = rst_n;
    p_mvalid = M_TVALID;
    p_mready = M_TREADY;
    p_mlast  = M_TLAST;
    p_mdata  = M_TDATA;
    p_start  = start;
    p_busy   = busy;
    p_len    = len;
  end

  task automatic pulse_start(input logic [15:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      if (rnd_m) M_TREADY = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last, output int waited);
    bit got;
    got      = 1'b0;
    waited   = 0;
    S_TVALID = 1'b1;
    S_TDATA  = d;
    for (int c = 0; c < 300 && !got; c++) begin
      if (rnd_m) M_TREADY = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (S_TREADY) begin
        exp_q.push_back({last, d});
        s_hs_cyc.push_back(cyc);
        got = 1'b1;
      end else begin
        waited++;
      end
      @(posedge clk); #1;
    end
    if (!got) check_val("s_accept_timeout", 72'(0), 72'(1));
    S_TVALID = 1'b0;
  endtask

  task automatic wait_drain();
    bit fin;
    fin = 1'b0;
    M_TREADY = 1'b1;
    for (int c = 0; c < 100 && !fin; c++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) fin = 1'b1;
      @(posedge clk); #1;
    end
    check_val("drain_complete", 72'(fin), 72'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    logic [63:0] d0, d1, d2;

    // reset state
    @(posedge clk);
    @(negedge clk);
    check_val("rst_outputs",
              72'({busy, done, S_TREADY, M_TVALID, M_TLAST, M_TSTRB, M_TDATA}), 72'(0));
    @(posedge clk);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // len=4, full rate
    s_hs_cyc.delete();
    m_hs_cyc.delete();
    M_TREADY = 1'b1;
    pulse_start(16'd4);
    check_val("busy_run", 72'(busy), 72'(1));
    for (int i = 0; i < 4; i++) begin
      send_beat({$urandom, $urandom}, (i == 3), w);
      check_val("s_full_rate", 72'(w), 72'(0));
    end
    wait_drain();
    check_val("m_beats_len4", 72'(m_hs_cyc.size()), 72'(4));
    if (m_hs_cyc.size() == 4 && s_hs_cyc.size() == 4)
      for (int i = 0; i < 4; i++)
        check_val("m_latency", 72'(m_hs_cyc[i]), 72'(s_hs_cyc[i] + 1));

    // len=3 with DMA backpressure
    d0 = {$urandom, $urandom};
    d1 = {$urandom, $urandom};
    d2 = {$urandom, $urandom};
    M_TREADY = 1'b0;
    pulse_start(16'd3);
    send_beat(d0, 1'b0, w);
    send_beat(d1, 1'b0, w);
    check_val("bp_second_beat", 72'(w), 72'(0));
    S_TVALID = 1'b1;
    S_TDATA  = d2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("bp_s_ready_low", 72'(S_TREADY), 72'(0));
      check_val("bp_head_data", 72'(M_TDATA), 72'(d0));
      @(posedge clk); #1;
    end
    M_TREADY = 1'b1;
    send_beat(d2, 1'b1, w);
    wait_drain();

    // len=0
    pulse_start(16'd0);
    @(negedge clk);
    check_val("zero_done", 72'(done), 72'(1));
    check_val("zero_busy", 72'(busy), 72'(0));
    check_val("zero_s_ready", 72'(S_TREADY), 72'(0));
    @(posedge clk); #1;
    idle(2);

    // start while busy is ignored; extra core beat stalls until the next frame
    M_TREADY = 1'b1;
    pulse_start(16'd2);
    send_beat({$urandom, $urandom}, 1'b0, w);
    pulse_start(16'd9);
    send_beat({$urandom, $urandom}, 1'b1, w);
    d2 = {$urandom, $urandom};
    S_TVALID = 1'b1;
    S_TDATA  = d2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("stall_s_ready", 72'(S_TREADY), 72'(0));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_val("ign_busy_clear", 72'(busy), 72'(0));
    @(posedge clk); #1;
    pulse_start(16'd1);
    send_beat(d2, 1'b1, w);
    wait_drain();

    // reset mid-frame with two beats buffered
    M_TREADY = 1'b0;
    pulse_start(16'd5);
    send_beat({$urandom, $urandom}, 1'b0, w);
    send_beat({$urandom, $urandom}, 1'b0, w);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_val("midrst_m_valid", 72'(M_TVALID), 72'(0));
    check_val("midrst_busy", 72'(busy), 72'(0));
    check_val("midrst_s_ready", 72'(S_TREADY), 72'(0));
    check_val("midrst_strb", 72'(M_TSTRB), 72'(0));
    @(posedge clk); #1;
    M_TREADY = 1'b1;
    pulse_start(16'd1);
    send_beat({$urandom, $urandom}, 1'b1, w);
    wait_drain();

    // long frame with random source gaps and random DMA ready
    n_beats = 0;
    n_lasts = 0;
    rnd_m   = 1'b1;
    pulse_start(16'd1000);
    for (int i = 0; i < 1000; i++) begin
      idle($urandom_range(0, 2));
      send_beat({$urandom, $urandom}, (i == 999), w);
    end
    rnd_m = 1'b0;
    wait_drain();
    check_val("rand_beats", 72'(n_beats), 72'(1000));
    check_val("rand_lasts", 72'(n_lasts), 72'(1));
    check_val("rand_q_empty", 72'(exp_q.size()), 72'(0));
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
